// File: rtl/popcount_pkg.sv
// popcount_pkg: shared sizing helpers and FSM state type for popcount_serial.
package popcount_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    function automatic int ow_f(input int w);
        return $clog2(w + 1);
    endfunction
    function automatic int nchunk_f(input int w, input int c);
        return (w + c - 1) / c;
    endfunction
endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: exact combinational popcount of CHUNK bits as a binary adder tree.
module popcount_chunk #(
    parameter int CHUNK = 9,
    parameter int CW = $clog2(CHUNK + 1)
) (
    input  logic [CHUNK-1:0] bits_i,
    output logic [CW-1:0]    count_o
);
    localparam int P = 2 ** $clog2(CHUNK);
    // Heap-ordered tree: node[1] is the root, leaves sit at node[P..2P-1].
    logic [CW-1:0] node [1:2*P-1];
    for (genvar i = 0; i < P; i++) begin : g_leaf
        if (i < CHUNK) begin : g_bit
            assign node[P+i] = CW'(bits_i[i]);
        end else begin : g_pad
            assign node[P+i] = '0;
        end
    end
    for (genvar n = 1; n < P; n++) begin : g_sum
        assign node[n] = node[2*n] + node[2*n+1];
    end
    assign count_o = node[1];
endmodule

// File: rtl/popcount_serial.sv
// popcount_serial: multi-cycle chunked popcount with optional LSB truncation and threshold fire bit.
module popcount_serial
    import popcount_pkg::*;
#(
    parameter int WIDTH = 27,
    parameter int CHUNK = 9,
    parameter int DROP_LSBS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          input_a,
    input  logic [ow_f(WIDTH)-1:0]    thr,
    input  logic                      approx_en,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ow_f(WIDTH)-1:0]    out_count,
    output logic                      out_fire
);
    localparam int OW = ow_f(WIDTH);
    localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
    localparam int PW = NCHUNK * CHUNK;
    localparam int CW = $clog2(CHUNK + 1);
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [OW-1:0] MASK = ~((OW'(1) << DROP_LSBS) - OW'(1));

    state_t state_q, state_d;
    logic [PW-1:0] vec_q, vec_d;
    logic [OW-1:0] thr_q, thr_d, acc_q, acc_d, count_q, count_d;
    logic [IW-1:0] idx_q, idx_d;
    logic apx_q, apx_d, fire_q, fire_d;
    logic [CHUNK-1:0] chunk;
    logic [CW-1:0] pc;
    logic [OW-1:0] sum, res;

    assign chunk = CHUNK'(vec_q >> (int'(idx_q) * CHUNK));

    popcount_chunk #(.CHUNK(CHUNK), .CW(CW)) u_chunk (.bits_i(chunk), .count_o(pc));

    assign sum = acc_q + OW'(pc);
    assign res = apx_q ? (sum & MASK) : sum;

    always_comb begin
        state_d = state_q;
        vec_d = vec_q;
        thr_d = thr_q;
        apx_d = apx_q;
        acc_d = acc_q;
        idx_d = idx_q;
        count_d = count_q;
        fire_d = fire_q;
        case (state_q)
            IDLE: if (in_valid) begin
                state_d = ACC;
                vec_d = PW'(input_a);
                thr_d = thr;
                apx_d = approx_en;
                acc_d = '0;
                idx_d = '0;
            end
            ACC: begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
                // Result registers load on the final chunk so DONE presents them directly.
                if (idx_q == IW'(NCHUNK - 1)) begin
                    state_d = DONE;
                    count_d = res;
                    fire_d = res >= thr_q;
                end
            end
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q <= '0;
            thr_q <= '0;
            apx_q <= 1'b0;
            acc_q <= '0;
            idx_q <= '0;
            count_q <= '0;
            fire_q <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q <= vec_d;
            thr_q <= thr_d;
            apx_q <= apx_d;
            acc_q <= acc_d;
            idx_q <= idx_d;
            count_q <= count_d;
            fire_q <= fire_d;
        end
    end

    assign in_ready = state_q == IDLE;
    assign out_valid = state_q == DONE;
    assign out_count = count_q;
    assign out_fire = fire_q;
endmodule

// File: tb/tb_popcount_serial.sv
// tb_popcount_serial: directed and random checks of popcount_serial at default and 10/4/0 parameters.
module tb_popcount_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic a_iv = 0, a_ir, a_apx = 0, a_ov, a_or = 0, a_fire;
    logic [26:0] a_in = '0;
    logic [4:0] a_thr = '0, a_cnt;
    logic b_iv = 0, b_ir, b_apx = 0, b_ov, b_or = 0, b_fire;
    logic [9:0] b_in = '0;
    logic [3:0] b_thr = '0, b_cnt;

    int passed = 0, total = 0;

    popcount_serial u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .input_a(a_in),
        .thr(a_thr), .approx_en(a_apx), .out_valid(a_ov), .out_ready(a_or),
        .out_count(a_cnt), .out_fire(a_fire)
    );

    popcount_serial #(.WIDTH(10), .CHUNK(4), .DROP_LSBS(0)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .input_a(b_in),
        .thr(b_thr), .approx_en(b_apx), .out_valid(b_ov), .out_ready(b_or),
        .out_count(b_cnt), .out_fire(b_fire)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one vector to u0 and wait for out_valid; lat counts edges after acceptance.
    task automatic send0(input logic [26:0] a, input logic [4:0] t, input logic apx, output int lat);
        a_in = a; a_thr = t; a_apx = apx; a_iv = 1;
        tick();
        a_iv = 0;
        lat = 0;
        while (!a_ov && lat < 20) begin tick(); lat++; end
    endtask

    task automatic send1(input logic [9:0] a, input logic [3:0] t, input logic apx, output int lat);
        b_in = a; b_thr = t; b_apx = apx; b_iv = 1;
        tick();
        b_iv = 0;
        lat = 0;
        while (!b_ov && lat < 20) begin tick(); lat++; end
    endtask

    task automatic rel0();
        a_or = 1; tick(); a_or = 0;
        chk("rel0_in_ready", int'(a_ir), 1);
        chk("rel0_out_valid", int'(a_ov), 0);
    endtask

    task automatic rel1();
        b_or = 1; tick(); b_or = 0;
    endtask

    initial begin
        int lat, exp, expa, c;
        logic [26:0] va;
        logic [9:0] vb;
        logic [4:0] ta;
        logic [3:0] tb;
        #12;
        chk("rst_in_ready", int'(a_ir), 1);
        chk("rst_out_valid", int'(a_ov), 0);
        chk("rst_count", int'(a_cnt), 0);
        chk("rst_fire", int'(a_fire), 0);
        rst_n = 1;
        tick();

        send0(27'h7FFFFFF, 5'd27, 0, lat);
        chk("ones_exact_lat", lat, 3);
        chk("ones_exact_cnt", int'(a_cnt), 27);
        chk("ones_exact_fire", int'(a_fire), 1);
        rel0();

        send0(27'h7FFFFFF, 5'd27, 1, lat);
        chk("ones_apx_cnt", int'(a_cnt), 26);
        chk("ones_apx_fire", int'(a_fire), 0);
        rel0();

        send0(27'h5, 5'd0, 1, lat);
        chk("h5_apx_cnt", int'(a_cnt), 2);
        rel0();

        send0(27'h0, 5'd0, 0, lat);
        chk("zero_thr0_cnt", int'(a_cnt), 0);
        chk("zero_thr0_fire", int'(a_fire), 1);
        rel0();
        send0(27'h0, 5'd1, 0, lat);
        chk("zero_thr1_fire", int'(a_fire), 0);
        rel0();

        send0(27'h00F0F0F, 5'd12, 0, lat);
        for (int i = 0; i < 10; i++) begin
            a_iv = 1; a_in = 27'h7FFFFFF; a_thr = 5'd0;
            tick();
            chk("bp_out_valid", int'(a_ov), 1);
            chk("bp_in_ready", int'(a_ir), 0);
            chk("bp_cnt", int'(a_cnt), 12);
            chk("bp_fire", int'(a_fire), 1);
        end
        a_iv = 0;
        rel0();

        a_in = 27'h7FFFFFF; a_thr = 5'd0; a_apx = 0; a_iv = 1;
        tick();
        a_iv = 0;
        tick();
        rst_n = 0;
        #1;
        chk("mid_rst_in_ready", int'(a_ir), 1);
        chk("mid_rst_out_valid", int'(a_ov), 0);
        #2 rst_n = 1;
        tick();
        chk("post_rst_in_ready", int'(a_ir), 1);
        chk("post_rst_out_valid", int'(a_ov), 0);
        send0(27'h7FF, 5'd11, 0, lat);
        chk("post_rst_lat", lat, 3);
        chk("post_rst_cnt", int'(a_cnt), 11);
        chk("post_rst_fire", int'(a_fire), 1);
        rel0();

        send1(10'h3FF, 4'd10, 0, lat);
        chk("w10_lat", lat, 3);
        chk("w10_cnt", int'(b_cnt), 10);
        chk("w10_fire", int'(b_fire), 1);
        rel1();

        for (int i = 0; i < 1000; i++) begin
            vb = 10'($urandom);
            tb = 4'($urandom_range(0, 10));
            c = $countones(vb);
            send1(vb, tb, 1'(i & 1), lat);
            chk("w10_rand_cnt", int'(b_cnt), c);
            chk("w10_rand_fire", int'(b_fire), int'(c >= int'(tb)));
            rel1();
        end

        for (int i = 0; i < 200; i++) begin
            va = 27'($urandom);
            ta = 5'($urandom_range(0, 27));
            exp = $countones(va);
            expa = (i & 1) ? (exp & ~1) : exp;
            send0(va, ta, 1'(i & 1), lat);
            chk("w27_rand_cnt", int'(a_cnt), expa);
            chk("w27_rand_fire", int'(a_fire), int'(expa >= int'(ta)));
            chk("w27_rand_err", int'((exp - int'(a_cnt)) >= 0 && (exp - int'(a_cnt)) <= 1), 1);
            a_or = 1; tick(); a_or = 0;
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
